kmkz_writeback: RTL and testbench

Writeback stage of the Kamikaze-uRV pipeline, directly downstream of the execute stage. It consumes the X/W pipeline registers, tracks the AHB-Lite data phase of loads and stores issued by execute, aligns and sign/zero-extends load data, and selects the result source. It drives the register-file write port and a one-cycle bypass register for forwarding, and raises a stall request while a data phase is outstanding.

---
 rtl/kmkz_writeback.sv | 183 ++++++++++++++++++
 tb/tb_kmkz_writeback.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/kmkz_writeback.sv
// ============================================================================
// Module   : kmkz_writeback
// Brief    : Kamikaze-uRV writeback stage. Tracks the AHB-Lite data phase,
//            aligns load data, drives the RF write port and the bypass register.
// Options  : KMKZ_WB_BUS_ERROR_EN enables HRESP error handling.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module kmkz_writeback (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        w_stall_i,
    input  logic [2:0]  x_fun_i,
    input  logic        x_load_i,
    input  logic        x_store_i,
    input  logic        x_valid_i,
    input  logic [4:0]  x_rd_i,
    input  logic        x_rd_write_i,
    input  logic [31:0] x_rd_value_i,
    input  logic [31:0] x_rd_shifter_i,
    input  logic [31:0] x_rd_multiply_i,
    input  logic [1:0]  x_rd_source_i,
    input  logic [31:0] x_dm_addr_i,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_rd_value_o,
    output logic        rf_rd_write_o,
    output logic [4:0]  w_bypass_rd_o,
    output logic [31:0] w_bypass_value_o,
    output logic        w_bypass_write_o,
    output logic        w_stall_req_o,
    output logic        w_bus_error_o,
    output logic [31:0] w_bus_error_addr_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ERROR = 2'd2
    } state_t;

    localparam logic [2:0] FUN_B  = 3'b000;
    localparam logic [2:0] FUN_H  = 3'b001;
    localparam logic [2:0] FUN_BU = 3'b100;
    localparam logic [2:0] FUN_HU = 3'b101;

    state_t      state;
    state_t      next_state;
    logic        mem;
    logic        complete;
    logic        errored;
    logic        err_resp;
    logic        rf_write;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;
    logic [31:0] result;

    assign mem      = x_valid_i & (x_load_i | x_store_i);
    assign complete = !mem | HREADY;

`ifdef KMKZ_WB_BUS_ERROR_EN
    assign err_resp = HRESP;
    // A ready cycle is errored if HRESP is high now or an error phase preceded it.
    assign errored  = mem & HREADY & (HRESP | (state == S_ERROR));
`else
    logic unused_bus_bits;
    assign err_resp        = 1'b0;
    assign errored         = 1'b0;
    assign unused_bus_bits = ^{HRESP, x_dm_addr_i[31:2]};
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (!w_stall_i) begin
            case (state)
                S_IDLE: begin
                    if (mem && !HREADY) begin
                        next_state = err_resp ? S_ERROR : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!mem || HREADY) begin
                        next_state = S_IDLE;
                    end else if (err_resp) begin
                        next_state = S_ERROR;
                    end
                end
                S_ERROR: begin
                    if (!mem || HREADY) begin
                        next_state = S_IDLE;
                    end
                end
                default: next_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        load_byte = HRDATA[7:0];
        case (x_dm_addr_i[1:0])
            2'd0: load_byte = HRDATA[7:0];
            2'd1: load_byte = HRDATA[15:8];
            2'd2: load_byte = HRDATA[23:16];
            2'd3: load_byte = HRDATA[31:24];
            default: load_byte = HRDATA[7:0];
        endcase
        load_half = x_dm_addr_i[1] ? HRDATA[31:16] : HRDATA[15:0];
        case (x_fun_i)
            FUN_B:   load_data = {{24{load_byte[7]}}, load_byte};
            FUN_BU:  load_data = {24'd0, load_byte};
            FUN_H:   load_data = {{16{load_half[15]}}, load_half};
            FUN_HU:  load_data = {16'd0, load_half};
            default: load_data = HRDATA;
        endcase
    end

    always_comb begin
        result = x_rd_value_i;
        if (x_load_i) begin
            result = load_data;
        end else begin
            case (x_rd_source_i)
                2'd1:    result = x_rd_shifter_i;
                2'd2:    result = x_rd_multiply_i;
                default: result = x_rd_value_i;
            endcase
        end
    end

    assign rf_write = x_valid_i & x_rd_write_i & !x_store_i & !w_stall_i & complete & !errored;

    // Combinational outputs are forced to zero while reset is held.
    assign rf_rd_write_o = rst_i & rf_write;
    assign rf_rd_o       = rst_i ? x_rd_i : 5'd0;
    assign rf_rd_value_o = rst_i ? result : 32'd0;
    assign w_stall_req_o = rst_i & mem & !HREADY;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            w_bypass_rd_o    <= 5'd0;
            w_bypass_value_o <= 32'd0;
            w_bypass_write_o <= 1'b0;
        end else if (!w_stall_i) begin
            w_bypass_write_o <= rf_write;
            if (rf_write) begin
                w_bypass_rd_o    <= x_rd_i;
                w_bypass_value_o <= result;
            end
        end
    end

`ifdef KMKZ_WB_BUS_ERROR_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            w_bus_error_o      <= 1'b0;
            w_bus_error_addr_o <= 32'd0;
        end else if (!w_stall_i) begin
            w_bus_error_o <= errored;
            if (errored) begin
                w_bus_error_addr_o <= x_dm_addr_i;
            end
        end
    end
`else
    assign w_bus_error_o      = 1'b0;
    assign w_bus_error_addr_o = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_kmkz_writeback.sv
// ============================================================================
// Module   : tb_kmkz_writeback
// Brief    : Directed self-checking bench for kmkz_writeback.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_kmkz_writeback;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        w_stall_i;
    logic [2:0]  x_fun_i;
    logic        x_load_i, x_store_i, x_valid_i;
    logic [4:0]  x_rd_i;
    logic        x_rd_write_i;
    logic [31:0] x_rd_value_i, x_rd_shifter_i, x_rd_multiply_i;
    logic [1:0]  x_rd_source_i;
    logic [31:0] x_dm_addr_i;
    logic [31:0] HRDATA;
    logic        HREADY, HRESP;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_rd_value_o;
    logic        rf_rd_write_o;
    logic [4:0]  w_bypass_rd_o;
    logic [31:0] w_bypass_value_o;
    logic        w_bypass_write_o;
    logic        w_stall_req_o;
    logic        w_bus_error_o;
    logic [31:0] w_bus_error_addr_o;

    int n_checks = 0;
    int n_fail   = 0;

    kmkz_writeback dut (
        .clk_i(clk_i), .rst_i(rst_i), .w_stall_i(w_stall_i),
        .x_fun_i(x_fun_i), .x_load_i(x_load_i), .x_store_i(x_store_i),
        .x_valid_i(x_valid_i), .x_rd_i(x_rd_i), .x_rd_write_i(x_rd_write_i),
        .x_rd_value_i(x_rd_value_i), .x_rd_shifter_i(x_rd_shifter_i),
        .x_rd_multiply_i(x_rd_multiply_i), .x_rd_source_i(x_rd_source_i),
        .x_dm_addr_i(x_dm_addr_i), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
        .rf_rd_o(rf_rd_o), .rf_rd_value_o(rf_rd_value_o), .rf_rd_write_o(rf_rd_write_o),
        .w_bypass_rd_o(w_bypass_rd_o), .w_bypass_value_o(w_bypass_value_o),
        .w_bypass_write_o(w_bypass_write_o), .w_stall_req_o(w_stall_req_o),
        .w_bus_error_o(w_bus_error_o), .w_bus_error_addr_o(w_bus_error_addr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; checks follow 1 ns later.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        w_stall_i = 0; x_fun_i = 3'b010; x_load_i = 0; x_store_i = 0; x_valid_i = 0;
        x_rd_i = 0; x_rd_write_i = 0; x_rd_value_i = 0; x_rd_shifter_i = 0;
        x_rd_multiply_i = 0; x_rd_source_i = 0; x_dm_addr_i = 0; HRDATA = 0;
        HREADY = 1; HRESP = 0;
    endtask

    task automatic load(input logic [2:0] fun, input logic [4:0] rd,
                        input logic [31:0] addr, input logic [31:0] data, input logic rdy);
        x_valid_i = 1; x_load_i = 1; x_store_i = 0; x_rd_write_i = 1;
        x_fun_i = fun; x_rd_i = rd; x_dm_addr_i = addr; HRDATA = data; HREADY = rdy;
    endtask

    initial begin
        idle_inputs();
        rst_i  = 0;
        x_rd_i = 5'd7;
        #12;
        chk("reset rf_rd", {27'd0, rf_rd_o}, 32'd0);
        chk("reset rf_write", {31'd0, rf_rd_write_o}, 32'd0);
        chk("reset rf_value", rf_rd_value_o, 32'd0);
        chk("reset bypass_write", {31'd0, w_bypass_write_o}, 32'd0);
        chk("reset bypass_value", w_bypass_value_o, 32'd0);
        chk("reset stall", {31'd0, w_stall_req_o}, 32'd0);
        chk("reset bus_error", {31'd0, w_bus_error_o}, 32'd0);
        chk("reset bus_error_addr", w_bus_error_addr_o, 32'd0);
        cyc();
        rst_i = 1;

        // Zero-wait loads of each width
        cyc();
        load(3'b000, 5'd3, 32'h1003, 32'h80123456, 1'b1); #1;
        chk("LB value", rf_rd_value_o, 32'hFFFFFF80);
        chk("LB write", {31'd0, rf_rd_write_o}, 32'd1);
        chk("LB rd", {27'd0, rf_rd_o}, 32'd3);
        chk("LB stall", {31'd0, w_stall_req_o}, 32'd0);
        cyc();
        load(3'b101, 5'd4, 32'h1002, 32'hBEEF1234, 1'b1); #1;
        chk("LB bypass value", w_bypass_value_o, 32'hFFFFFF80);
        chk("LB bypass rd", {27'd0, w_bypass_rd_o}, 32'd3);
        chk("LB bypass write", {31'd0, w_bypass_write_o}, 32'd1);
        chk("LHU value", rf_rd_value_o, 32'h0000BEEF);
        cyc();
        load(3'b001, 5'd4, 32'h1000, 32'hBEEF1234, 1'b1); #1;
        chk("LH value", rf_rd_value_o, 32'h00001234);
        chk("LHU bypass value", w_bypass_value_o, 32'h0000BEEF);
        cyc();
        load(3'b100, 5'd4, 32'h1003, 32'h80123456, 1'b1); #1;
        chk("LBU value", rf_rd_value_o, 32'h00000080);

        // LW with three wait states
        cyc();
        load(3'b010, 5'd6, 32'h3000, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("LW wait stall", {31'd0, w_stall_req_o}, 32'd1);
            chk("LW wait write", {31'd0, rf_rd_write_o}, 32'd0);
            if (k == 2) chk("LW wait bypass write", {31'd0, w_bypass_write_o}, 32'd0);
            cyc();
        end
        HREADY = 1; HRDATA = 32'hCAFEF00D; #1;
        chk("LW done stall", {31'd0, w_stall_req_o}, 32'd0);
        chk("LW done write", {31'd0, rf_rd_write_o}, 32'd1);
        chk("LW done value", rf_rd_value_o, 32'hCAFEF00D);
        cyc();
        idle_inputs(); #1;
        chk("LW bypass value", w_bypass_value_o, 32'hCAFEF00D);
        chk("LW bypass write", {31'd0, w_bypass_write_o}, 32'd1);
        chk("idle write", {31'd0, rf_rd_write_o}, 32'd0);
        cyc(); #1;
        chk("bypass one cycle", {31'd0, w_bypass_write_o}, 32'd0);

        // Non-memory result sources, store, x0 and stall
        cyc();
        x_valid_i = 1; x_rd_write_i = 1; x_rd_i = 5'd5; x_rd_source_i = 2'd1;
        x_rd_shifter_i = 32'h000000F0; x_rd_value_i = 32'h1111; x_rd_multiply_i = 32'h2222;
        HREADY = 0; #1;
        chk("shift value", rf_rd_value_o, 32'h000000F0);
        chk("shift write", {31'd0, rf_rd_write_o}, 32'd1);
        chk("shift rd", {27'd0, rf_rd_o}, 32'd5);
        chk("non-mem stall", {31'd0, w_stall_req_o}, 32'd0);
        cyc();
        HREADY = 1; x_rd_source_i = 2'd2; #1;
        chk("mul value", rf_rd_value_o, 32'h2222);
        cyc();
        x_rd_source_i = 2'd3; #1;
        chk("csr value", rf_rd_value_o, 32'h1111);
        cyc();
        x_store_i = 1; x_rd_source_i = 2'd0; #1;
        chk("store write", {31'd0, rf_rd_write_o}, 32'd0);
        cyc();
        x_store_i = 0; x_rd_i = 5'd0; #1;
        chk("x0 write", {31'd0, rf_rd_write_o}, 32'd1);
        cyc();
        w_stall_i = 1; x_rd_i = 5'd8; x_rd_value_i = 32'h3333; #1;
        chk("stalled write", {31'd0, rf_rd_write_o}, 32'd0);
        cyc(); #1;
        chk("stall holds bypass write", {31'd0, w_bypass_write_o}, 32'd1);
        chk("stall holds bypass rd", {27'd0, w_bypass_rd_o}, 32'd0);
        chk("stall holds bypass value", w_bypass_value_o, 32'h1111);
        cyc();
        idle_inputs();

        // Two-cycle AHB error response
        cyc();
        load(3'b010, 5'd9, 32'h2000, 32'h12345678, 1'b0);
        HRESP = 1; #1;
        chk("err phase1 stall", {31'd0, w_stall_req_o}, 32'd1);
        chk("err phase1 write", {31'd0, rf_rd_write_o}, 32'd0);
        cyc();
        HREADY = 1; #1;
`ifdef KMKZ_WB_BUS_ERROR_EN
        chk("err phase2 write", {31'd0, rf_rd_write_o}, 32'd0);
        chk("err phase2 stall", {31'd0, w_stall_req_o}, 32'd0);
        cyc();
        idle_inputs(); #1;
        chk("bus_error pulse", {31'd0, w_bus_error_o}, 32'd1);
        chk("bus_error addr", w_bus_error_addr_o, 32'h00002000);
        cyc(); #1;
        chk("bus_error cleared", {31'd0, w_bus_error_o}, 32'd0);
        chk("bus_error addr held", w_bus_error_addr_o, 32'h00002000);
`else
        chk("HRESP ignored write", {31'd0, rf_rd_write_o}, 32'd1);
        chk("HRESP ignored value", rf_rd_value_o, 32'h12345678);
        cyc();
        idle_inputs(); #1;
        chk("bus_error tied", {31'd0, w_bus_error_o}, 32'd0);
        chk("bus_error addr tied", w_bus_error_addr_o, 32'd0);
`endif

        // Reset asserted mid-WAIT
        cyc();
        load(3'b010, 5'd10, 32'h4000, 32'h0, 1'b0);
        cyc(); #1;
        chk("pre-reset stall", {31'd0, w_stall_req_o}, 32'd1);
        rst_i = 0; #1;
        chk("mid-reset stall", {31'd0, w_stall_req_o}, 32'd0);
        chk("mid-reset write", {31'd0, rf_rd_write_o}, 32'd0);
        chk("mid-reset rf_rd", {27'd0, rf_rd_o}, 32'd0);
        chk("mid-reset bypass value", w_bypass_value_o, 32'd0);
        chk("mid-reset bypass write", {31'd0, w_bypass_write_o}, 32'd0);
        cyc();
        rst_i = 1;
        load(3'b010, 5'd10, 32'h4000, 32'h0BADCAFE, 1'b1); #1;
        chk("post-reset LW write", {31'd0, rf_rd_write_o}, 32'd1);
        chk("post-reset LW value", rf_rd_value_o, 32'h0BADCAFE);
        cyc(); #1;
        chk("post-reset bypass", w_bypass_value_o, 32'h0BADCAFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
